// File: rtl/fifo_rd_stream.sv
// Read-side drain stage: pops the async FIFO's fall-through port into a
// 2-entry buffer and presents the words on a valid/ready stream.
module fifo_rd_stream #(
  parameter int DATA_SIZE = 12,
  parameter int CNT_SIZE  = 16
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 rEmpty,
  input  logic [DATA_SIZE-1:0] rData,
  output logic                 rinc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic [1:0]           buf_level,
  output logic [CNT_SIZE-1:0]  word_cnt
);

  logic [1:0]           lvl_q, lvl_d;
  logic [DATA_SIZE-1:0] head_q, head_d;
  logic [DATA_SIZE-1:0] tail_q, tail_d;
  logic [CNT_SIZE-1:0]  cnt_q, cnt_d;
  logic                 push_s;
  logic                 pop_s;

  // Pop decode uses only registered level and FIFO/flush inputs, never out_ready;
  // rrst gating keeps rinc low during reset even if rEmpty is not yet high.
  always_comb begin
    push_s = rrst & ~rEmpty & (lvl_q != 2'd2) & ~flush;
    pop_s  = (lvl_q != 2'd0) & out_ready;
  end

  // Buffer, level and handshake-counter next state.
  always_comb begin
    lvl_d  = lvl_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (pop_s) begin
      cnt_d = cnt_q + {{(CNT_SIZE-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
    case ({push_s, pop_s})
      2'b10: begin
        if (lvl_q == 2'd0) begin
          head_d = rData;
        end else begin
          tail_d = rData;
        end
        lvl_d = lvl_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        lvl_d  = lvl_q - 2'd1;
      end
      2'b11: begin
        // New word queues behind the departing head, level unchanged.
        if (lvl_q == 2'd2) begin
          head_d = tail_q;
          tail_d = rData;
        end else begin
          head_d = rData;
        end
      end
      default: begin
        lvl_d = lvl_q;
      end
    endcase
    if (flush) begin
      lvl_d = 2'd0;
    end else begin
      lvl_d = lvl_d;
    end
  end

  // State registers.
  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      lvl_q  <= 2'd0;
      head_q <= {DATA_SIZE{1'b0}};
      tail_q <= {DATA_SIZE{1'b0}};
      cnt_q  <= {CNT_SIZE{1'b0}};
    end else begin
      lvl_q  <= lvl_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Output mapping.
  always_comb begin
    rinc      = push_s;
    out_valid = (lvl_q != 2'd0);
    out_data  = head_q;
    buf_level = lvl_q;
    word_cnt  = cnt_q;
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a queue models the async FIFO, a second
// queue holds words expected on the stream in order.
module tb_fifo_rd_stream;
  localparam int DW = 12;
  localparam int CW = 4;

  logic          rclk = 1'b0;
  logic          rrst;
  logic          rEmpty;
  logic [DW-1:0] rData;
  logic          rinc;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    buf_level;
  logic [CW-1:0] word_cnt;

  fifo_rd_stream #(.DATA_SIZE(DW), .CNT_SIZE(CW)) dut (
    .rclk(rclk), .rrst(rrst), .rEmpty(rEmpty), .rData(rData), .rinc(rinc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .buf_level(buf_level), .word_cnt(word_cnt)
  );

  always #5 rclk = ~rclk;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            m_lvl = 0;
  int            m_cnt = 0;
  int            dut_pops = 0;
  int            pops_before;
  logic [DW-1:0] next_word;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    rEmpty = (fifo_q.size() == 0);
    rData  = rEmpty ? '0 : fifo_q[0];
  endtask

  task automatic add_words(input int n);
    repeat (n) begin
      fifo_q.push_back(next_word);
      next_word = next_word + 1'b1;
    end
    drive_fifo();
  endtask

  // One clock: check outputs against the model, then advance the model.
  task automatic cycle();
    logic e_rinc;
    logic e_pop;
    #1;
    e_rinc = rrst & ~rEmpty & (m_lvl != 2) & ~flush;
    e_pop  = (m_lvl != 0) & out_ready;
    check("rinc", {31'd0, rinc}, {31'd0, e_rinc});
    check("out_valid", {31'd0, out_valid}, {31'd0, (m_lvl != 0)});
    check("buf_level", {30'd0, buf_level}, m_lvl);
    check("word_cnt", {28'd0, word_cnt}, m_cnt);
    if (m_lvl != 0) check("out_data", {20'd0, out_data}, {20'd0, sb_q[0]});
    if (rinc === 1'b1) dut_pops++;
    @(posedge rclk);
    #1;
    if (e_pop) begin
      void'(sb_q.pop_front());
      m_cnt = (m_cnt + 1) % (1 << CW);
    end
    if (flush) sb_q.delete();
    if (e_rinc) sb_q.push_back(fifo_q.pop_front());
    m_lvl = sb_q.size();
    drive_fifo();
    @(negedge rclk);
  endtask

  initial begin
    rrst = 1'b0; flush = 1'b0; out_ready = 1'b0; next_word = 12'h001;
    drive_fifo();
    #3;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_level", {30'd0, buf_level}, 32'd0);
    check("rst_cnt", {28'd0, word_cnt}, 32'd0);
    check("rst_data", {20'd0, out_data}, 32'd0);
    rEmpty = 1'b0; rData = 12'hABC;
    #1;
    check("rst_rinc_forced", {31'd0, rinc}, 32'd0);
    drive_fifo();
    @(negedge rclk);
    rrst = 1'b1;

    // Preloaded 0x001..0x005 streamed with out_ready high.
    add_words(5);
    out_ready = 1'b1;
    repeat (8) cycle();
    check("pre_cnt", {28'd0, word_cnt}, 32'd5);
    check("pre_level", {30'd0, buf_level}, 32'd0);

    // Backpressure: exactly two pops, first word held.
    out_ready = 1'b0;
    add_words(4);
    pops_before = dut_pops;
    repeat (4) cycle();
    check("bp_pops", dut_pops - pops_before, 32'd2);
    check("bp_level", {30'd0, buf_level}, 32'd2);
    check("bp_head", {20'd0, out_data}, 32'h006);
    out_ready = 1'b1;
    repeat (6) cycle();

    // Alternating ready with a bursty supply.
    for (int i = 0; i < 60; i++) begin
      out_ready = i[0];
      if (fifo_q.size() < 3) add_words($urandom_range(0, 2));
      cycle();
    end
    out_ready = 1'b1;
    repeat (8) cycle();

    // Flush with a full buffer and a handshake in the same cycle.
    out_ready = 1'b0;
    add_words(4);
    repeat (3) cycle();
    check("fl_level_pre", {30'd0, buf_level}, 32'd2);
    out_ready = 1'b1;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("fl_level_post", {30'd0, buf_level}, 32'd0);
    repeat (6) cycle();

    // Drive the counter through a wrap.
    for (int i = 0; i < 20; i++) begin
      if (fifo_q.size() < 2) add_words(2);
      cycle();
    end
    repeat (4) cycle();

    // Asynchronous reset with a full buffer mid-stream.
    out_ready = 1'b0;
    add_words(3);
    repeat (3) cycle();
    #2;
    rrst = 1'b0;
    #1;
    check("ar_valid", {31'd0, out_valid}, 32'd0);
    check("ar_level", {30'd0, buf_level}, 32'd0);
    check("ar_cnt", {28'd0, word_cnt}, 32'd0);
    check("ar_data", {20'd0, out_data}, 32'd0);
    check("ar_rinc", {31'd0, rinc}, 32'd0);
    sb_q.delete(); fifo_q.delete();
    m_lvl = 0; m_cnt = 0;
    drive_fifo();
    @(negedge rclk);
    rrst = 1'b1;
    out_ready = 1'b1;
    add_words(3);
    repeat (6) cycle();
    check("ar_restart_cnt", {28'd0, word_cnt}, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
